// File: rtl/mdu_pkg.sv
// Shared definitions for the MIPS E-stage multiply/divide unit: op codes,
// FSM states and default latencies.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8,
    OP_MADD  = 4'd9
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam int unsigned MDU_MULT_CYCLES = 5;
  localparam int unsigned MDU_DIV_CYCLES  = 10;

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit {hi,lo} result for mult/multu/div/divu, plus a
// divide-by-zero flag. MDU_MADD_EN adds the accumulate input and MADD.
module mdu_arith
  import mdu_pkg::*;
(
  input  mdu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef MDU_MADD_EN
  input  logic [63:0] acc,
`endif
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic [63:0] sa, sb, ua, ub;
  logic [31:0] a_abs, b_abs, q_mag, r_mag, q_s, r_s;

  always_comb begin
    sa     = {{32{a[31]}}, a};
    sb     = {{32{b[31]}}, b};
    ua     = {32'b0, a};
    ub     = {32'b0, b};
    a_abs  = a[31] ? -a : a;
    b_abs  = b[31] ? -b : b;
    q_mag  = '0;
    r_mag  = '0;
    q_s    = '0;
    r_s    = '0;
    result = '0;
    div_by_zero = 1'b0;
    case (op)
      OP_MULT:  result = sa * sb;
      OP_MULTU: result = ua * ub;
      OP_DIV: begin
        div_by_zero = (b == '0);
        // Magnitude divide then re-sign; 0x80000000 / -1 falls out as 0x80000000 rem 0.
        if (b != '0) begin
          q_mag = a_abs / b_abs;
          r_mag = a_abs % b_abs;
        end
        q_s    = (a[31] ^ b[31]) ? -q_mag : q_mag;
        r_s    = a[31] ? -r_mag : r_mag;
        result = {r_s, q_s};
      end
      OP_DIVU: begin
        div_by_zero = (b == '0);
        if (b != '0) result = {a % b, a / b};
      end
`ifdef MDU_MADD_EN
      OP_MADD:  result = acc + sa * sb;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit holding architectural HI/LO, with the
// start/busy handshake for the hazard unit. MDU_MADD_EN enables MADD.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        req,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  mdu_op_e    op;
  mdu_state_e state;
  logic [CW-1:0] count;
  logic [31:0]   pend_hi, pend_lo;
  logic [63:0]   result;
  logic          div_by_zero;
  logic          is_muldiv, is_div;

  assign op = mdu_op_e'(mdu_op);

  mdu_arith u_arith (
    .op          (op),
    .a           (src_a),
    .b           (src_b),
`ifdef MDU_MADD_EN
    .acc         ({hi, lo}),
`endif
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  always_comb begin
    is_div    = (op == OP_DIV) || (op == OP_DIVU);
    is_muldiv = is_div || (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
    if (op == OP_MADD) is_muldiv = 1'b1;
`endif
    start = is_muldiv && !req && (state == ST_IDLE);
    case (op)
      OP_MFHI: rdata = hi;
      OP_MFLO: rdata = lo;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      count   <= '0;
      busy    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            // Divide by zero commits the current HI/LO back, leaving them unchanged.
            if (div_by_zero) begin
              pend_hi <= hi;
              pend_lo <= lo;
            end else begin
              pend_hi <= result[63:32];
              pend_lo <= result[31:0];
            end
            count <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            busy  <= 1'b1;
            state <= ST_BUSY;
          end else if (!req) begin
            if (op == OP_MTHI) hi <= src_a;
            if (op == OP_MTLO) lo <= src_a;
          end
        end
        ST_BUSY: begin
          if (count == CW'(1)) begin
            hi    <= pend_hi;
            lo    <= pend_lo;
            busy  <= 1'b0;
            count <= '0;
            state <= ST_IDLE;
          end else begin
            count <= count - CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: each launch pushes the expected HI/LO and
// busy length; a monitor checks them when busy falls. Honours MDU_MADD_EN.
module tb_mdu_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  mdu_op;
  logic [31:0] src_a, src_b;
  logic        req;
  logic        start, busy;
  logic [31:0] hi, lo, rdata;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned cyc;
  } exp_t;
  exp_t sb[$];

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .mdu_op (mdu_op),
    .src_a  (src_a),
    .src_b  (src_b),
    .req    (req),
    .start  (start),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo),
    .rdata  (rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input string name, input logic [31:0] h, input logic [31:0] l,
                      input int unsigned cyc);
    exp_t e;
    e.name = name; e.hi = h; e.lo = l; e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic run_monitor();
    exp_t        e;
    int unsigned bcnt = 0;
    logic        prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        bcnt = 0;
        prev = 1'b0;
      end else begin
        if (busy) bcnt++;
        else if (prev) begin
          if (sb.size() == 0) check("unexpected commit", 32'd1, 32'd0);
          else begin
            e = sb.pop_front();
            check({e.name, " hi"}, hi, e.hi);
            check({e.name, " lo"}, lo, e.lo);
            check({e.name, " busy cycles"}, bcnt, e.cyc);
          end
          bcnt = 0;
        end
        prev = busy;
      end
    end
  endtask

  // Called at posedge+1; presents the op for one clock edge.
  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic exp_start, input string name);
    mdu_op = op; src_a = a; src_b = b;
    #1 check({name, " start"}, {31'b0, start}, {31'b0, exp_start});
    @(posedge clk); #1;
    mdu_op = OP_NONE; src_a = '0; src_b = '0;
  endtask

  task automatic wait_idle(input string name);
    int unsigned n = 0;
    while (busy && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " idle timeout"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; mdu_op = OP_NONE; src_a = '0; src_b = '0; req = 1'b0;
    fork run_monitor(); join_none
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // mult 7 * -3, one-cycle start, five busy cycles
    push("mult 7*-3", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5);
    launch(OP_MULT, 32'd7, 32'hFFFF_FFFD, 1'b1, "mult");
    check("mult busy c1", {31'b0, busy}, 32'd1);
    check("mult start drop", {31'b0, start}, 32'd0);
    wait_idle("mult");

    // same mult, reset asserted in busy cycle 3
    launch(OP_MULT, 32'd7, 32'hFFFF_FFFD, 1'b1, "mult rst");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrst busy", {31'b0, busy}, 32'd0);
    check("midrst hi", hi, 32'd0);
    check("midrst lo", lo, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("midrst no commit hi", hi, 32'd0);
    check("midrst no commit lo", lo, 32'd0);

    push("divu", 32'h0000_000F, 32'h0FFF_FFFF, 10);
    launch(OP_DIVU, 32'hFFFF_FFFF, 32'h10, 1'b1, "divu");
    wait_idle("divu");

    push("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    launch(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, "div");
    wait_idle("div");

    launch(OP_MTHI, 32'h11, 32'h0, 1'b0, "mthi 11");
    launch(OP_MTLO, 32'h22, 32'h0, 1'b0, "mtlo 22");
    check("mthi hi", hi, 32'h11);
    check("mtlo lo", lo, 32'h22);
    push("div by zero", 32'h11, 32'h22, 10);
    launch(OP_DIV, 32'd5, 32'd0, 1'b1, "div0");
    wait_idle("div0");

    push("div ovf", 32'h0, 32'h8000_0000, 10);
    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div ovf");
    wait_idle("div ovf");

    // req in the start cycle suppresses the launch
    req = 1'b1;
    launch(OP_MULT, 32'd3, 32'd3, 1'b0, "mult req");
    req = 1'b0;
    check("req busy", {31'b0, busy}, 32'd0);
    check("req hi", hi, 32'h0);
    check("req lo", lo, 32'h8000_0000);

    // req during busy does not abort
    push("multu req busy", 32'h0, 32'd12, 5);
    launch(OP_MULTU, 32'd3, 32'd4, 1'b1, "multu");
    req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    wait_idle("multu");
    req = 1'b0;

    launch(OP_MTHI, 32'hDEAD_0000, 32'h0, 1'b0, "mthi dead");
    mdu_op = OP_MFHI;
    #1 check("mfhi rdata", rdata, 32'hDEAD_0000);
    mdu_op = OP_NONE;
    #1 check("none rdata", rdata, 32'h0);
    @(posedge clk); #1;

    // mult and mtlo while busy are both ignored
    push("mult 2*3", 32'h0, 32'd6, 5);
    launch(OP_MULT, 32'd2, 32'd3, 1'b1, "mult 2*3");
    launch(OP_MULT, 32'd9, 32'd9, 1'b0, "mult busy");
    launch(OP_MTLO, 32'h0BAD, 32'h0, 1'b0, "mtlo busy");
    check("mtlo busy lo", lo, 32'd12);
    check("mtlo busy busy", {31'b0, busy}, 32'd1);
    wait_idle("mult 2*3");

    mdu_op = OP_MFLO;
    #1 check("mflo rdata", rdata, 32'd6);
    mdu_op = OP_NONE;
    @(posedge clk); #1;

    launch(OP_MTHI, 32'h0, 32'h0, 1'b0, "mthi 0");
    launch(OP_MTLO, 32'hFFFF_FFFF, 32'h0, 1'b0, "mtlo ff");
`ifdef MDU_MADD_EN
    push("madd", 32'd1, 32'd0, 5);
    launch(OP_MADD, 32'd1, 32'd1, 1'b1, "madd");
    wait_idle("madd");
`else
    launch(OP_MADD, 32'd1, 32'd1, 1'b0, "madd off");
    check("madd off busy", {31'b0, busy}, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("madd off hi", hi, 32'h0);
    check("madd off lo", lo, 32'hFFFF_FFFF);
`endif

    wait_idle("final");
    @(negedge clk); #1;
    check("scoreboard drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Executes mult/multu/div/divu over several cycles and holds the architectural HI/LO registers.
- Drives the start/busy pair that the hazard unit uses to stall mfhi/mflo/mthi/mtlo and to clear follow-on mult/div ops in D.
- Accepts the exception flush request from CP0 so that an op in E is not committed when the instruction ahead of it traps.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- mdu_op  input  4  E-stage operation code (package encoding)
- src_a  input  32  rs operand (forwarded)
- src_b  input  32  rt operand (forwarded)
- req  input  1  exception/interrupt flush; suppresses any new effect of the E-stage op
- start  output  1  a mult/div is being launched this cycle
- busy  output  1  a mult/div is in progress
- hi  output  32  architectural HI
- lo  output  32  architectural LO
- rdata  output  32  mfhi -> hi, mflo -> lo, otherwise 0

Behaviour:
- Reset (async, active-high): state IDLE, counter 0, hi = lo = 0, busy = 0, pending result 0.
- start and rdata are combinational. busy, hi and lo are registered.
- start = (mdu_op is MULT, MULTU, DIV or DIVU) && !req && state == IDLE.
- States:
  - IDLE: on start, latch the full result into pend_hi/pend_lo and load counter with MULT_CYCLES or DIV_CYCLES; go to BUSY.
  - BUSY: busy = 1; counter decrements each cycle. On the edge where counter == 1, hi <= pend_hi, lo <= pend_lo, busy falls and the state returns to IDLE.
- Timing: busy is high for exactly N cycles, starting the cycle after start. The new HI/LO values are visible in the first cycle busy is low.
- mult: {hi,lo} = signed 64-bit product. multu: unsigned 64-bit product.
- div: lo = quotient truncated toward zero; hi = remainder, with the sign of the dividend.
- divu: unsigned quotient and remainder.
- Divide by zero: busy still lasts DIV_CYCLES; HI/LO are left unchanged.
- div 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0. No trap.
- mthi/mtlo: write src_a into hi/lo on the clock edge when state == IDLE && !req.
- Ops in illegal timing: any mult/div/mt op arriving while BUSY is ignored. The hazard unit guarantees this does not occur; the block is still safe if it does.
- req during BUSY does not abort; the op already launched commits normally.
- req in the start cycle: nothing launches and state stays IDLE.
- mfhi/mflo during BUSY return the old HI/LO. The hazard unit stalls these, so this is not architecturally visible.
- Simultaneous commit and mt op cannot happen, because mt ops are ignored outside IDLE.
- Reset mid-operation aborts immediately; the pending result is discarded.

Optional Feature:
- Macro MDU_MADD_EN.
- When defined:
  - Adds MADD (SPECIAL2 funct 0x00): {hi,lo} <= {hi,lo} + signed(src_a)*signed(src_b), mod 2^64.
  - Uses MULT_CYCLES latency. The accumulate base is the HI/LO value at the start cycle.
  - start is also asserted for MADD.
- When not defined: the MADD encoding is treated as NONE (no start, no effect).

Decomposition:
- Shared package mdu_pkg holds:
  - op codes NONE 0, MULT 1, MULTU 2, DIV 3, DIVU 4, MFHI 5, MFLO 6, MTHI 7, MTLO 8, MADD 9;
  - state encoding IDLE/BUSY;
  - default cycle constants.
- The E-stage decoder imports this package to produce mdu_op.
- One natural sub-module: mdu_arith, purely combinational, 64-bit result for each op incl. div-by-zero flag.
- mdu_unit owns the FSM, counter and HI/LO.

Test Plan:
- Reset mid-BUSY:
  - mult 7 * -3 -> start 1 for one cycle; busy high cycles 1..5; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB from cycle 6.
  - Assert reset at cycle 3 -> busy, hi and lo go 0 asynchronously.
- divu vs div:
  - divu 0xFFFFFFFF / 0x10 -> lo = 0x0FFFFFFF, hi = 0xF after 10 busy cycles.
  - div -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- Division corner cases:
  - div 5 / 0 -> busy 10 cycles; prior hi = 0x11, lo = 0x22 retained.
  - div 0x80000000 / -1 -> lo = 0x80000000, hi = 0.
- req interaction:
  - mult with req = 1 in the start cycle -> start 0, busy stays 0, HI/LO unchanged.
  - req = 1 during BUSY -> result still commits.
- mt/mf path:
  - mthi 0xDEAD0000, then mfhi -> rdata = 0xDEAD0000.
  - mtlo while BUSY -> ignored.
  - mflo while idle -> rdata = lo.
- MADD, with MDU_MADD_EN defined:
  - hi = 0, lo = 0xFFFFFFFF, madd 1 * 1 -> hi = 1, lo = 0.
- MADD, without MDU_MADD_EN:
  - madd -> start 0, HI/LO unchanged.
